sifreleme_hatti: RTL

SIFRELEME_HATTI -- requirements
Module: sifreleme_hatti

---
 rtl/sifreleme_hatti_pkg.sv | 26 ++
 rtl/sifreleme_hatti_sayim.sv | 35 +++
 rtl/sifreleme_hatti.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sifreleme_hatti_pkg.sv
// Shared definitions for the bit-manipulation pipeline: operation codes and
// FSM state encodings used by the top level and by the testbench.
package sifreleme_hatti_pkg;

  // Operation codes; values match the original single-cycle unit
  localparam logic [2:0] SIFRELEME_PKG   = 3'd0;
  localparam logic [2:0] SIFRELEME_RVRS  = 3'd1;
  localparam logic [2:0] SIFRELEME_SLADD = 3'd2;
  localparam logic [2:0] SIFRELEME_HMDST = 3'd3;
  localparam logic [2:0] SIFRELEME_CNTZ  = 3'd4;
  localparam logic [2:0] SIFRELEME_CNTP  = 3'd5;

  // Controller states
  typedef enum logic [1:0] {
    BOSTA   = 2'd0,
    HESAPLA = 2'd1,
    SONUC   = 2'd2
  } durum_e;

  // True for the operations that take the iterative counting path
  function automatic logic sayim_islemi_mi(input logic [2:0] kod);
    return (kod == SIFRELEME_HMDST) || (kod == SIFRELEME_CNTZ) ||
           (kod == SIFRELEME_CNTP);
  endfunction

endpackage

// File: rtl/sifreleme_hatti_sayim.sv
// One ADIM-bit step of the counting datapath: population count of the slice
// and the number of trailing zeros inside the slice (ADIM when it is all zero).
module sifreleme_sayim_adimi #(
  parameter int ADIM = 4
) (
  input  logic [ADIM-1:0]        dilim_i,
  output logic [$clog2(ADIM):0]  bir_sayisi_o,
  output logic [$clog2(ADIM):0]  sondaki_sifir_o,
  output logic                   sifir_degil_o
);
  localparam int PW = $clog2(ADIM) + 1;

  // Population count of the slice
  always_comb begin
    bir_sayisi_o = '0;
    for (int i = 0; i < ADIM; i++) begin
      bir_sayisi_o = bir_sayisi_o + PW'(dilim_i[i]);
    end
  end

  // Trailing-zero count: scan from MSB down so the lowest set bit wins
  always_comb begin
    sondaki_sifir_o = PW'(ADIM);
    for (int i = ADIM - 1; i >= 0; i--) begin
      if (dilim_i[i]) begin
        sondaki_sifir_o = PW'(i);
      end else begin
        sondaki_sifir_o = sondaki_sifir_o;
      end
    end
  end

  assign sifir_degil_o = |dilim_i;

endmodule

// File: rtl/sifreleme_hatti.sv
// Bit-manipulation pipeline with valid/ready handshakes. Pack, byte-reverse
// and shift-add finish in one cycle; popcount, Hamming distance and trailing
// zero count iterate ADIM bits per cycle with fixed, data-independent latency.
module sifreleme_hatti
  import sifreleme_hatti_pkg::*;
#(
  parameter int VERI_GENISLIGI = 32,
  parameter int ADIM           = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      temizle_i,
  input  logic                      istek_gecerli_i,
  output logic                      istek_hazir_o,
  input  logic [2:0]                kontrol_i,
  input  logic [VERI_GENISLIGI-1:0] deger1_i,
  input  logic [VERI_GENISLIGI-1:0] deger2_i,
  output logic                      sonuc_gecerli_o,
  input  logic                      sonuc_hazir_i,
  output logic [VERI_GENISLIGI-1:0] sonuc_o
);
  localparam int N           = VERI_GENISLIGI;
  localparam int SW          = $clog2(N) + 1;
  localparam int PW          = $clog2(ADIM) + 1;
  localparam int ADIM_SAYISI = N / ADIM;
  localparam logic [SW-1:0] SON_ADIM = SW'(ADIM_SAYISI - 1);

  durum_e          durum_q, durum_d;
  logic [2:0]      islem_q, islem_d;
  logic [N-1:0]    veri_q, veri_d;
  logic [SW-1:0]   sayac_q, sayac_d;
  logic [SW-1:0]   adim_q, adim_d;
  logic            bulundu_q, bulundu_d;
  logic [N-1:0]    sonuc_q, sonuc_d;

  logic            kabul_s;
  logic            son_adim_s;
  logic [N-1:0]    tek_sonuc_s;
  logic [SW-1:0]   sayac_sonraki_s;
  logic [PW-1:0]   bir_sayisi_s;
  logic [PW-1:0]   sondaki_sifir_s;
  logic            sifir_degil_s;

  assign kabul_s    = istek_gecerli_i && (durum_q == BOSTA);
  assign son_adim_s = (adim_q == SON_ADIM);

  sifreleme_sayim_adimi #(.ADIM(ADIM)) u_sayim_adimi (
    .dilim_i         (veri_q[ADIM-1:0]),
    .bir_sayisi_o    (bir_sayisi_s),
    .sondaki_sifir_o (sondaki_sifir_s),
    .sifir_degil_o   (sifir_degil_s)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q <= BOSTA;
    end else begin
      durum_q <= durum_d;
    end
  end

  // Next-state logic; abort overrides both handshakes
  always_comb begin
    durum_d = durum_q;
    if (temizle_i) begin
      durum_d = BOSTA;
    end else begin
      case (durum_q)
        BOSTA:   durum_d = !istek_gecerli_i ? BOSTA :
                           (sayim_islemi_mi(kontrol_i) ? HESAPLA : SONUC);
        HESAPLA: durum_d = son_adim_s ? SONUC : HESAPLA;
        SONUC:   durum_d = sonuc_hazir_i ? BOSTA : SONUC;
        default: durum_d = BOSTA;
      endcase
    end
  end

  // Handshake outputs decoded purely from the state register
  always_comb begin
    istek_hazir_o   = 1'b0;
    sonuc_gecerli_o = 1'b0;
    case (durum_q)
      BOSTA:   istek_hazir_o   = 1'b1;
      SONUC:   sonuc_gecerli_o = 1'b1;
      default: istek_hazir_o   = 1'b0;
    endcase
  end

  // Single-cycle results computed straight from the request operands
  always_comb begin
    tek_sonuc_s = '0;
    case (kontrol_i)
      SIFRELEME_PKG:   tek_sonuc_s = {deger2_i[N/2-1:0], deger1_i[N/2-1:0]};
      SIFRELEME_RVRS: begin
        for (int b = 0; b < N / 8; b++) begin
          tek_sonuc_s[8*b +: 8] = deger1_i[N-8-8*b +: 8];
        end
      end
      SIFRELEME_SLADD: tek_sonuc_s = (deger1_i << 1) + deger2_i;
      default:         tek_sonuc_s = '0;
    endcase
  end

  // Count accumulation for the current slice; CNTZ stops adding after the first one
  always_comb begin
    sayac_sonraki_s = sayac_q;
    case (islem_q)
      SIFRELEME_CNTZ: sayac_sonraki_s = bulundu_q ? sayac_q
                                                  : sayac_q + SW'(sondaki_sifir_s);
      default:        sayac_sonraki_s = sayac_q + SW'(bir_sayisi_s);
    endcase
  end

  // Datapath next-state: capture, iterate, publish
  always_comb begin
    islem_d   = islem_q;
    veri_d    = veri_q;
    sayac_d   = sayac_q;
    adim_d    = adim_q;
    bulundu_d = bulundu_q;
    sonuc_d   = sonuc_q;
    if (temizle_i) begin
      islem_d   = 3'd0;
      veri_d    = '0;
      sayac_d   = '0;
      adim_d    = '0;
      bulundu_d = 1'b0;
    end else if (kabul_s) begin
      islem_d   = kontrol_i;
      veri_d    = (kontrol_i == SIFRELEME_HMDST) ? (deger1_i ^ deger2_i) : deger1_i;
      sayac_d   = '0;
      adim_d    = '0;
      bulundu_d = 1'b0;
      sonuc_d   = sayim_islemi_mi(kontrol_i) ? sonuc_q : tek_sonuc_s;
    end else if (durum_q == HESAPLA) begin
      veri_d    = veri_q >> ADIM;
      sayac_d   = sayac_sonraki_s;
      adim_d    = adim_q + SW'(1);
      bulundu_d = bulundu_q | sifir_degil_s;
      sonuc_d   = son_adim_s ? {{(N-SW){1'b0}}, sayac_sonraki_s} : sonuc_q;
    end else begin
      sonuc_d   = sonuc_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      islem_q   <= 3'd0;
      veri_q    <= '0;
      sayac_q   <= '0;
      adim_q    <= '0;
      bulundu_q <= 1'b0;
      sonuc_q   <= '0;
    end else begin
      islem_q   <= islem_d;
      veri_q    <= veri_d;
      sayac_q   <= sayac_d;
      adim_q    <= adim_d;
      bulundu_q <= bulundu_d;
      sonuc_q   <= sonuc_d;
    end
  end

  assign sonuc_o = sonuc_q;

endmodule
